fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit and its queue.
package fetch_unit_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          QDEPTH_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; head reads zero when empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requester feeding a QDEPTH-entry queue to decode.
// Latency: out_valid rises two cycles after the first request with imem_ready high and a one-cycle memory.
// Backpressure: no issue while queued + outstanding reaches QDEPTH; imem_ready low holds the request stable.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = QDEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   req_pc, req_pc_nxt;
    logic [31:0]   hold_pc, hold_pc_nxt;
    logic          hold_vld, hold_vld_nxt;
    logic [31:0]   redir_tgt;

    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_wr;
    fetch_entry_t  q_rd;
    logic          resp_issue_ok;

    assign redir_tgt = redirect_pc & ~32'h3;
    assign q_pop     = out_ready && !q_empty;
    assign q_wr      = '{pc: req_pc, instr: imem_rdata};

    // After this push nothing is outstanding, so only the queue occupancy matters.
    assign resp_issue_ok = q_pop ? (q_count < CW'(QDEPTH)) : (q_count < CW'(QDEPTH - 1));

    // A redirect seen while a request is pending parks the old address here so the
    // request stays stable even though fetch_pc already holds the new target.
    assign imem_addr = hold_vld ? hold_pc : fetch_pc;
    assign imem_req  = (state == REQ);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        hold_pc_nxt  = hold_pc;
        hold_vld_nxt = hold_vld;
        q_push       = 1'b0;

        if (redirect_valid) fetch_pc_nxt = redir_tgt;

        case (state)
            IDLE: begin
                if (redirect_valid || !q_full) state_nxt = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    req_pc_nxt   = imem_addr;
                    hold_vld_nxt = 1'b0;
                    if (redirect_valid || hold_vld) begin
                        state_nxt = DROP;
                    end else begin
                        state_nxt    = RESP;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end
                end else if (redirect_valid && !hold_vld) begin
                    hold_vld_nxt = 1'b1;
                    hold_pc_nxt  = imem_addr;
                end
            end
            RESP: begin
                if (redirect_valid) begin
                    state_nxt = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    q_push    = 1'b1;
                    state_nxt = resp_issue_ok ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            hold_pc  <= '0;
            hold_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
            hold_pc  <= hold_pc_nxt;
            hold_vld <= hold_vld_nxt;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (q_push),
        .push_dat (q_wr),
        .pop      (q_pop),
        .flush    (redirect_valid),
        .head_dat (q_rd),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign out_valid = !q_empty;
    assign out_instr = q_rd.instr;
    assign out_pc    = q_rd.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a pc-stream model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata  = 32'h0;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;

    int          m_lat = 1;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wrap_pc[$];
    logic [31:0] wrap_instr[$];

    fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (w_imem_req),
        .imem_addr      (w_imem_addr),
        .imem_ready     (1'b1),
        .imem_rvalid    (w_rvalid),
        .imem_rdata     (w_rdata),
        .out_valid      (w_out_valid),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .out_ready      (1'b1),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0)
    );

    // Memory: not reset, answers addr+0x100 m_lat cycles after acceptance.
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (imem_req && imem_ready) begin
            m_addr <= imem_addr;
            if (m_lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= imem_addr + 32'h100;
                m_cnt       <= 0;
            end else begin
                m_cnt <= m_lat - 1;
            end
        end else if (m_cnt == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= m_addr + 32'h100;
            m_cnt       <= 0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) begin
        w_rvalid <= w_imem_req;
        w_rdata  <= w_imem_addr + 32'h100;
    end

    always @(negedge clk) begin
        if (rst_n && w_out_valid && wrap_pc.size() < 3) begin
            wrap_pc.push_back(w_out_pc);
            wrap_instr.push_back(w_out_instr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input int bound);
        int i = 0;
        while (!out_valid && i < bound) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        if (out_valid) begin
            check({tag, "_pc"}, out_pc, pc);
            check({tag, "_instr"}, out_instr, pc + 32'h100);
        end
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input int bound);
        int i = 0;
        while (!imem_req && i < bound) begin
            @(negedge clk);
            i++;
        end
        check(tag, {31'b0, imem_req}, 32'd1);
    endtask

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        out_ready      = 1'b1;
        m_lat          = lat;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          n_acc;
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit          prev_stall;
        bit          prev_redir;
        logic [31:0] wexp [3];

        rst_n          = 1'b0;
        imem_ready     = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;

        // Reset values
        @(negedge clk);
        check("rst_req",   {31'b0, imem_req},  32'd0);
        check("rst_addr",  imem_addr,          32'h0);
        check("rst_vld",   {31'b0, out_valid}, 32'd0);
        check("rst_instr", out_instr,          32'h0);
        check("rst_pc",    out_pc,             32'h0);
        check("rst_waddr", w_imem_addr,        32'hFFFF_FFF8);

        // Streaming with ready high and a one-cycle memory
        imem_ready = 1'b1;
        out_ready  = 1'b1;
        rst_n      = 1'b1;
        @(negedge clk);
        check("t1_req_first", {31'b0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_vld_c1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_vld_c2", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_vld_c3", {31'b0, out_valid}, 32'd1);
        expect_out("t1_0", 32'h0, 1);
        expect_out("t1_4", 32'h4, 6);
        expect_out("t1_8", 32'h8, 6);
        repeat (4) @(negedge clk);

        // Back-pressure: queue fills to QDEPTH and issue stops
        do_reset(1);
        out_ready = 1'b0;
        n_acc = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req && imem_ready) n_acc++;
        end
        check("t2_accepts", n_acc, 32'd2);
        check("t2_req_off", {31'b0, imem_req}, 32'd0);
        check("t2_vld", {31'b0, out_valid}, 32'd1);
        check("t2_head", out_pc, 32'h0);
        out_ready = 1'b1;
        expect_out("t2_0", 32'h0, 1);
        expect_out("t2_4", 32'h4, 2);
        expect_out("t2_8", 32'h8, 10);

        // Redirect while the response for 0x8 is outstanding
        do_reset(3);
        wait_req("t3_r0", 4);
        @(negedge clk);
        wait_req("t3_r1", 12);
        @(negedge clk);
        wait_req("t3_r2", 12);
        check("t3_addr8", imem_addr, 32'h8);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t3_flush", {31'b0, out_valid}, 32'd0);
        wait_req("t3_rq", 12);
        check("t3_addr40", imem_addr, 32'h40);
        expect_out("t3_40", 32'h40, 12);

        // imem_ready low for 3 cycles with a redirect inside the stall
        do_reset(1);
        imem_ready = 1'b0;
        @(negedge clk);
        check("t4_req1", {31'b0, imem_req}, 32'd1);
        check("t4_addr_c1", imem_addr, 32'h0);
        @(negedge clk);
        check("t4_addr_c2", imem_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t4_addr_c3", imem_addr, 32'h0);
        check("t4_req3", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        check("t4_addr_c4", imem_addr, 32'h0);
        imem_ready = 1'b1;
        @(negedge clk);
        wait_req("t4_rq", 6);
        check("t4_addr200", imem_addr, 32'h200);
        expect_out("t4_200", 32'h200, 8);

        // Reset pulled mid-RESP; the stale response lands after release
        do_reset(3);
        out_ready = 1'b0;
        wait_req("t5_r0", 4);
        @(negedge clk);
        wait_req("t5_r1", 12);
        check("t5_addr4", imem_addr, 32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_req",   {31'b0, imem_req},  32'd0);
        check("t5_rst_addr",  imem_addr,          32'h0);
        check("t5_rst_vld",   {31'b0, out_valid}, 32'd0);
        check("t5_rst_pc",    out_pc,             32'h0);
        check("t5_rst_instr", out_instr,          32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_req_held", {31'b0, imem_req}, 32'd1);
        check("t5_vld_none", {31'b0, out_valid}, 32'd0);
        imem_ready = 1'b1;
        out_ready  = 1'b1;
        m_lat      = 1;
        expect_out("t5_0", 32'h0, 8);

        // Address wrap on the instance reset at 0xFFFF_FFF8
        check("t6_count", wrap_pc.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < wrap_pc.size()) begin
                check($sformatf("t6_pc%0d", k), wrap_pc[k], wexp[k]);
                check($sformatf("t6_instr%0d", k), wrap_instr[k], wexp[k] + 32'h100);
            end
        end

        // Randomized: decode must see consecutive pcs restarting at each redirect target
        do_reset(1);
        exp_pc     = 32'h0;
        prev_addr  = 32'h0;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            if (prev_redir) check("r_flush", {31'b0, out_valid}, 32'd0);
            if (prev_stall) begin
                check("r_hold_req", {31'b0, imem_req}, 32'd1);
                check("r_hold_addr", imem_addr, prev_addr);
            end
            out_ready      = ($urandom_range(3) != 0);
            imem_ready     = ($urandom_range(2) != 0);
            redirect_valid = ($urandom_range(39) == 0);
            redirect_pc    = $urandom;
            m_lat          = 1 + $urandom_range(2);
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (out_valid && out_ready) begin
                check("r_pc", out_pc, exp_pc);
                check("r_instr", out_instr, exp_pc + 32'h100);
                exp_pc = exp_pc + 32'd4;
            end
            prev_redir = redirect_valid;
            prev_stall = imem_req && !imem_ready;
            prev_addr  = imem_addr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
